// File: rtl/sync_fifo_pkg.sv
// sync_fifo_pkg: shared defaults and pointer arithmetic for the single-clock FWFT FIFO
package sync_fifo_pkg;
  localparam int DEF_DATA_WIDTH = 8;
  localparam int DEF_ADDR_WIDTH = 4;

  function automatic logic [31:0] ptr_level(input logic [31:0] w, input logic [31:0] r);
    return w - r;
  endfunction
endpackage

// File: rtl/sync_fifo_flags_ram.sv
// fifo_ram: register-array storage with one synchronous write port and an asynchronous read port
module fifo_ram #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  clk_i,
  input  logic                  we_i,
  input  logic [ADDR_WIDTH-1:0] waddr_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  input  logic [ADDR_WIDTH-1:0] raddr_i,
  output logic [DATA_WIDTH-1:0] rdata_o
);
  logic [DATA_WIDTH-1:0] mem_q [1<<ADDR_WIDTH];
  assign rdata_o = mem_q[raddr_i];
  // storage is deliberately unreset; only accepted writes touch it
  always_ff @(posedge clk_i)
    if (we_i) mem_q[waddr_i] <= wdata_i;
endmodule

// File: rtl/sync_fifo_flags.sv
// sync_fifo_flags: single-clock FWFT FIFO with level, almost flags, sticky errors and flush
module sync_fifo_flags import sync_fifo_pkg::*; #(
  parameter int DATA_WIDTH         = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH         = DEF_ADDR_WIDTH,
  parameter int ALMOST_FULL_LEVEL  = (1 << ADDR_WIDTH) - 2,
  parameter int ALMOST_EMPTY_LEVEL = 2
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  flush,
  input  logic [DATA_WIDTH-1:0] write_data,
  input  logic                  write_enable,
  input  logic                  read_next,
  output logic [DATA_WIDTH-1:0] read_data,
  output logic                  read_empty,
  output logic                  write_full,
  output logic                  almost_empty,
  output logic                  almost_full,
  output logic [ADDR_WIDTH:0]   level,
  output logic                  overflow,
  output logic                  underflow
);
  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam int LW = ADDR_WIDTH + 1;

  if (!(ALMOST_EMPTY_LEVEL < ALMOST_FULL_LEVEL && ALMOST_FULL_LEVEL <= DEPTH)) begin : g_bad_thresholds
    $error("sync_fifo_flags: thresholds must satisfy ALMOST_EMPTY_LEVEL < ALMOST_FULL_LEVEL <= DEPTH");
  end

  logic [ADDR_WIDTH:0]   wr_q, wr_d, rd_q, rd_d;
  logic                  ovf_q, ovf_d, udf_q, udf_d;
  logic                  rd_ok, wr_ok;
  logic [DATA_WIDTH-1:0] ram_data;

  assign read_empty   = wr_q == rd_q;
  assign write_full   = (wr_q ^ rd_q) == {1'b1, {ADDR_WIDTH{1'b0}}};
  assign rd_ok        = read_next && !read_empty;
  assign wr_ok        = write_enable && (!write_full || rd_ok);
  assign level        = LW'(ptr_level(32'(wr_q), 32'(rd_q)));
  assign almost_empty = level <= LW'(ALMOST_EMPTY_LEVEL);
  assign almost_full  = level >= LW'(ALMOST_FULL_LEVEL);
  assign overflow     = ovf_q;
  assign underflow    = udf_q;
  assign read_data    = read_empty ? '0 : ram_data;

  // flush empties the FIFO and clears errors; otherwise pointers advance on accepted ops
  always_comb begin
    wr_d  = flush ? '0 : wr_q + LW'(wr_ok);
    rd_d  = flush ? '0 : rd_q + LW'(rd_ok);
    ovf_d = !flush && (ovf_q || (write_enable && !wr_ok));
    udf_d = !flush && (udf_q || (read_next && read_empty));
  end

  // pointer and sticky error registers with synchronous active-low reset
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      wr_q  <= '0;
      rd_q  <= '0;
      ovf_q <= 1'b0;
      udf_q <= 1'b0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      ovf_q <= ovf_d;
      udf_q <= udf_d;
    end
  end

  fifo_ram #(.DATA_WIDTH(DATA_WIDTH), .ADDR_WIDTH(ADDR_WIDTH)) u_ram (
    .clk_i   (clock),
    .we_i    (wr_ok && !flush && reset_n),
    .waddr_i (wr_q[ADDR_WIDTH-1:0]),
    .wdata_i (write_data),
    .raddr_i (rd_q[ADDR_WIDTH-1:0]),
    .rdata_o (ram_data)
  );
endmodule

// File: tb/tb_sync_fifo_flags.sv
// tb_sync_fifo_flags: queue-model self-checking bench for sync_fifo_flags
module tb_sync_fifo_flags;
  logic       clock = 1'b0;
  logic       reset_n = 1'b0;
  logic       flush = 1'b0;
  logic [7:0] write_data = '0;
  logic       write_enable = 1'b0;
  logic       read_next = 1'b0;
  logic [7:0] read_data;
  logic       read_empty, write_full, almost_empty, almost_full, overflow, underflow;
  logic [4:0] level;

  int checks = 0;
  int errors = 0;
  bit model_ok = 0;
  logic [7:0] mq[$];
  bit m_ovf = 0;
  bit m_udf = 0;

  sync_fifo_flags dut (
    .clock(clock), .reset_n(reset_n), .flush(flush), .write_data(write_data),
    .write_enable(write_enable), .read_next(read_next), .read_data(read_data),
    .read_empty(read_empty), .write_full(write_full), .almost_empty(almost_empty),
    .almost_full(almost_full), .level(level), .overflow(overflow), .underflow(underflow)
  );

  always #5 clock = ~clock;

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  // reference model: a queue of stored words, updated from the rules of acceptance
  always @(posedge clock) begin
    bit e, f, ro, wo;
    if (!reset_n || flush) begin
      mq.delete();
      m_ovf = 0;
      m_udf = 0;
      model_ok = model_ok || !reset_n;
    end else begin
      e  = mq.size() == 0;
      f  = mq.size() == 16;
      ro = read_next && !e;
      wo = write_enable && (!f || ro);
      if (write_enable && !wo) m_ovf = 1;
      if (read_next && e) m_udf = 1;
      if (ro) void'(mq.pop_front());
      if (wo) mq.push_back(write_data);
    end
  end

  always @(negedge clock) begin
    if (model_ok) begin
      int n;
      n = mq.size();
      cmp("m_level", 32'(level), n);
      cmp("m_empty", 32'(read_empty), 32'(n == 0));
      cmp("m_full", 32'(write_full), 32'(n == 16));
      cmp("m_aempty", 32'(almost_empty), 32'(n <= 2));
      cmp("m_afull", 32'(almost_full), 32'(n >= 14));
      cmp("m_data", 32'(read_data), n == 0 ? 0 : 32'(mq[0]));
      cmp("m_ovf", 32'(overflow), 32'(m_ovf));
      cmp("m_udf", 32'(underflow), 32'(m_udf));
    end
  end

  task automatic step(input logic we, input logic [7:0] wd, input logic rn, input logic fl, input logic rst);
    write_enable = we;
    write_data = wd;
    read_next = rn;
    flush = fl;
    reset_n = !rst;
    @(posedge clock);
    #2;
    write_enable = 0;
    read_next = 0;
    flush = 0;
    reset_n = 1;
  endtask

  task automatic post_reset(input string tag);
    cmp({tag, "_level"}, 32'(level), 0);
    cmp({tag, "_empty"}, 32'(read_empty), 1);
    cmp({tag, "_full"}, 32'(write_full), 0);
    cmp({tag, "_aempty"}, 32'(almost_empty), 1);
    cmp({tag, "_afull"}, 32'(almost_full), 0);
    cmp({tag, "_data"}, 32'(read_data), 0);
    cmp({tag, "_ovf"}, 32'(overflow), 0);
    cmp({tag, "_udf"}, 32'(underflow), 0);
  endtask

  initial begin
    step(0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0);
    post_reset("rst");
    for (int i = 1; i <= 16; i++) begin
      step(1, 8'(i), 0, 0, 0);
      cmp("fill_level", 32'(level), i);
      cmp("fill_data", 32'(read_data), 1);
      cmp("fill_aempty", 32'(almost_empty), 32'(i <= 2));
      cmp("fill_afull", 32'(almost_full), 32'(i >= 14));
      cmp("fill_full", 32'(write_full), 32'(i == 16));
    end
    step(1, 17, 0, 0, 0);
    cmp("ovf_set", 32'(overflow), 1);
    cmp("ovf_level", 32'(level), 16);
    step(1, 99, 1, 0, 0);
    cmp("rw_full_level", 32'(level), 16);
    cmp("rw_full_data", 32'(read_data), 2);
    for (int k = 3; k <= 16; k++) begin
      step(0, 0, 1, 0, 0);
      cmp("drain_data", 32'(read_data), k);
    end
    step(0, 0, 1, 0, 0);
    cmp("drain_last", 32'(read_data), 99);
    cmp("drain_level", 32'(level), 1);
    step(0, 0, 1, 0, 0);
    cmp("drained_empty", 32'(read_empty), 1);
    step(1, 8'h5A, 1, 0, 0);
    cmp("udf_set", 32'(underflow), 1);
    cmp("udf_level", 32'(level), 1);
    cmp("udf_data", 32'(read_data), 8'h5A);
    step(0, 0, 0, 1, 0);
    for (int i = 0; i < 8; i++) step(1, 8'(100 + i), 0, 0, 0);
    for (int i = 0; i < 40; i++) step(1, 8'(108 + i), 1, 0, 0);
    cmp("wrap_head", 32'(read_data), 140);
    cmp("wrap_level", 32'(level), 8);
    step(0, 0, 0, 1, 0);
    step(0, 0, 1, 0, 0);
    cmp("pre_flush_udf", 32'(underflow), 1);
    for (int i = 0; i < 10; i++) step(1, 8'(i + 1), 0, 0, 0);
    step(1, 8'hEE, 0, 1, 0);
    post_reset("flush");
    for (int i = 0; i < 5; i++) step(1, 8'(i + 7), 0, 0, 0);
    step(1, 8'h33, 1, 0, 1);
    post_reset("midrst");
    for (int i = 0; i < 600; i++) begin
      int bias;
      bias = (i / 100) % 3 == 0 ? 85 : (i / 100) % 3 == 1 ? 15 : (mq.size() < 8 ? 70 : 30);
      step($urandom_range(0, 99) < bias, 8'($urandom), $urandom_range(0, 99) < 100 - bias,
           $urandom_range(0, 59) == 0, $urandom_range(0, 199) == 0);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
